// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_pkg
// Description : Shared ALU control codes, funct/ALUOp encodings and the issue
//               sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_pkg;

    localparam logic [2:0] c_ctrl_and = 3'b000;
    localparam logic [2:0] c_ctrl_or  = 3'b001;
    localparam logic [2:0] c_ctrl_add = 3'b010;
    localparam logic [2:0] c_ctrl_mul = 3'b100;
    localparam logic [2:0] c_ctrl_sub = 3'b110;

    localparam logic [5:0] c_funct_add = 6'b100000;
    localparam logic [5:0] c_funct_sub = 6'b100010;
    localparam logic [5:0] c_funct_and = 6'b100100;
    localparam logic [5:0] c_funct_or  = 6'b100101;
    localparam logic [5:0] c_funct_mul = 6'b011000;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_rtype = 2'b10;
    localparam logic [1:0] c_aluop_or    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MULW = 2'd2,
        DONE = 2'd3
    } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_funct_dec.sv
`default_nettype none
// ============================================================================
// Module      : alu_funct_dec
// Description : Combinational (ALUOp, funct) -> ALU control decoder.
//               MUL decodes only when ALU_ISSUE_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_funct_dec
    import alu_issue_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = c_ctrl_add;
        illegal_o = 1'b0;
        case (aluop_i)
            c_aluop_add: ctrl_o = c_ctrl_add;
            c_aluop_sub: ctrl_o = c_ctrl_sub;
            c_aluop_or:  ctrl_o = c_ctrl_or;
            default: begin
                case (funct_i)
                    c_funct_add: ctrl_o = c_ctrl_add;
                    c_funct_sub: ctrl_o = c_ctrl_sub;
                    c_funct_and: ctrl_o = c_ctrl_and;
                    c_funct_or:  ctrl_o = c_ctrl_or;
`ifdef ALU_ISSUE_MUL_EN
                    c_funct_mul: ctrl_o = c_ctrl_mul;
`endif
                    // Undecodable funct falls back to ADD and is flagged
                    default: begin
                        ctrl_o    = c_ctrl_add;
                        illegal_o = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_seq
// Description : Issues one operation at a time to an external combinational
//               ALU and returns the result over a valid/ready handshake.
//               Define ALU_ISSUE_MUL_EN to enable multi-cycle MUL support.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_seq
    import alu_issue_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  ALUOp_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic [31:0] imm_i,
    input  logic        ALUSrc_i,
    output logic [31:0] alu_data1_o,
    output logic [31:0] alu_data2_o,
    output logic [2:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i,
    output logic [31:0] result_o,
    output logic        result_valid_o,
    input  logic        ready_i,
    output logic        illegal_o
);

    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_mul_lat_check
        $error("alu_issue_seq: MUL_LAT must be in 1..15");
    end

    alu_state_t  r_state;
    alu_state_t  w_next;
    logic [31:0] r_data1;
    logic [31:0] r_data2;
    logic [2:0]  r_ctrl;
    logic [31:0] r_result;
    logic        r_illegal;
    logic        w_accept;
    logic        w_capture;
    logic [2:0]  w_dec_ctrl;
    logic        w_dec_illegal;

    alu_funct_dec u_dec (
        .aluop_i   (ALUOp_i),
        .funct_i   (funct_i),
        .ctrl_o    (w_dec_ctrl),
        .illegal_o (w_dec_illegal)
    );

    assign ready_o        = (r_state == IDLE) && !rst_i;
    assign w_accept       = valid_i && ready_o;
    assign alu_data1_o    = r_data1;
    assign alu_data2_o    = r_data2;
    assign alu_ctrl_o     = r_ctrl;
    assign result_o       = r_result;
    assign result_valid_o = (r_state == DONE);
    assign illegal_o      = r_illegal;

`ifdef ALU_ISSUE_MUL_EN
    localparam logic [3:0] c_cnt_load = 4'(MUL_LAT - 1);
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_dec;
    logic       w_mul_wait;

    assign w_cnt_dec  = r_cnt - 4'd1;
    assign w_mul_wait = (r_ctrl == c_ctrl_mul) && (MUL_LAT > 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= 4'd0;
        end else if (r_state == EXEC && w_mul_wait) begin
            r_cnt <= c_cnt_load;
        end else if (r_state == MULW) begin
            r_cnt <= w_cnt_dec;
        end
    end
`endif

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            IDLE: if (w_accept) w_next = EXEC;
            EXEC: begin
`ifdef ALU_ISSUE_MUL_EN
                if (w_mul_wait) begin
                    w_next = MULW;
                end else begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end
`else
                w_capture = 1'b1;
                w_next    = DONE;
`endif
            end
`ifdef ALU_ISSUE_MUL_EN
            // Capture on the cycle the counter decrements to zero
            MULW: begin
                if (w_cnt_dec == 4'd0) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end
            end
`endif
            DONE: if (ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_data1   <= 32'd0;
            r_data2   <= 32'd0;
            r_ctrl    <= c_ctrl_and;
            r_result  <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_accept && w_dec_illegal;
            if (w_accept) begin
                r_data1 <= rs_data_i;
                r_data2 <= ALUSrc_i ? imm_i : rt_data_i;
                r_ctrl  <= w_dec_ctrl;
            end
            if (w_capture) begin
                r_result <= alu_result_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_seq.md
ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 The block SHALL take parameter MUL_LAT, default 3: number of cycles a MUL holds operands stable on the ALU inputs (legal range 1..15).
REQ-002 The block SHALL have port clk_i, input, 1: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port valid_i, input, 1: the upstream operation is valid.
REQ-005 The block SHALL have port ready_o, output, 1: the block accepts an operation this cycle.
REQ-006 The block SHALL have port ALUOp_i, input, 2: 00 add, 01 sub, 10 R-type (decode funct), 11 or.
REQ-007 The block SHALL have port funct_i, input, 6: R-type function field.
REQ-008 The block SHALL have ports rs_data_i and rt_data_i, input, 32 each: register operands.
REQ-009 The block SHALL have ports imm_i, input, 32: sign-extended immediate; and ALUSrc_i, input, 1: 1 selects imm_i as the second operand.
REQ-010 The block SHALL have ports alu_data1_o and alu_data2_o, output, 32 each; and alu_ctrl_o, output, 3: these drive the ALU operand and control inputs.
REQ-011 The block SHALL have port alu_result_i, input, 32: the ALU's combinational result.
REQ-012 The block SHALL have ports result_o, output, 32; result_valid_o, output, 1; ready_i, input, 1: downstream result handshake.
REQ-013 The block SHALL have port illegal_o, output, 1: one-cycle pulse on acceptance of an undecodable funct.

Function
REQ-014 ALUCtrl codes SHALL be: AND 000, OR 001, ADD 010, MUL 100, SUB 110.
REQ-015 R-type funct decode SHALL be: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 011000 MUL; any other value SHALL decode to ADD and pulse illegal_o in the cycle after acceptance.
REQ-016 The FSM SHALL have states IDLE, EXEC, MULW and DONE; ready_o SHALL be 1 only in IDLE while rst_i is 0.
REQ-017 On valid_i&&ready_o the block SHALL register the operands (data1=rs_data_i; data2=ALUSrc_i?imm_i:rt_data_i) and the decoded control, then go IDLE->EXEC.
REQ-018 alu_data1_o, alu_data2_o and alu_ctrl_o SHALL come directly from the operand/control registers and be stable from EXEC through MULW.
REQ-019 In EXEC with a non-MUL op, the block SHALL capture alu_result_i into result_o and go to DONE.
REQ-020 In EXEC with MUL, the block SHALL go to MULW and load a counter with MUL_LAT-1. If MUL_LAT=1, it SHALL instead capture the result in EXEC and go to DONE.
REQ-021 In MULW the counter SHALL decrement each cycle; at 0 the block SHALL capture alu_result_i and go to DONE.
REQ-022 Latency: with acceptance at edge 0, result_valid_o SHALL be high from cycle 2 for non-MUL ops and from cycle MUL_LAT+1 for MUL.
REQ-023 In DONE, result_valid_o SHALL be 1 and result_o SHALL hold. On ready_i=1 the FSM SHALL return to IDLE. If ready_i=0, DONE SHALL persist with no timeout.
REQ-024 valid_i outside IDLE SHALL be ignored; upstream holds valid_i until ready_o.
REQ-025 Arithmetic SHALL be modulo 2^32; overflow SHALL not be flagged.

Reset
REQ-026 When rst_i=1 at a clock edge, the block SHALL force state IDLE and clear the counter, the operand registers, the control register (000), result_o, result_valid_o and illegal_o.
REQ-027 ready_o SHALL be 0 while rst_i=1.
REQ-028 A reset in any state, including mid-MULW or DONE, SHALL abort the operation with no result delivered.

Configuration
REQ-029 With macro ALU_ISSUE_MUL_EN defined, MUL decode and the MULW state SHALL exist.
REQ-030 Without ALU_ISSUE_MUL_EN, funct 011000 SHALL be treated as illegal (ADD plus illegal_o), and no MULW state or counter SHALL be synthesised.

Structure
REQ-031 Shared package alu_issue_pkg SHALL hold the ALUCtrl code constants, the funct constants, the ALUOp encodings and the FSM state typedef.
REQ-032 The block SHALL use sub-module alu_funct_dec, a combinational decoder (ALUOp, funct) -> (ctrl, illegal).

Verification
REQ-033 ALUOp=10, funct=100010, rs=10, rt=3: alu_ctrl_o=110; model ALU returns 7; result_o=7 and result_valid_o=1 in cycle 2.
REQ-034 ALUOp=00, ALUSrc=1, rs=0x100, imm=0xFFFFFFFC: alu_data2_o=0xFFFFFFFC; result_o=0xFC.
REQ-035 MUL, MUL_LAT=3, rs=6, rt=7: ALU inputs stable for cycles 1-3; result_o=42 valid in cycle 4; ready_o=0 for cycles 1-4.
REQ-036 funct=111111: illegal_o pulses exactly once; alu_ctrl_o=010.
REQ-037 Hold ready_i=0 for 5 cycles in DONE: result_valid_o and result_o are stable; valid_i pulses are ignored; on ready_i=1 the block returns to IDLE next cycle.
REQ-038 Assert rst_i in the second MULW cycle: next cycle state=IDLE, all outputs 0, no result_valid_o.
